bpa_seq_add_ctrl: RTL
=====================

// Module: bpa_seq_add_ctrl
// PURPOSE
//   Multi-cycle sequencer for wide additions (N bits) using one shared W-bit carry-bypass adder slice.
//   The slice is built from M-bit bypass groups, as in the team's BPA_M/FA_M structure.
//   Each operand is processed one W-bit chunk per cycle, LSB chunk first.
//   The chunk carry-out is registered and fed into the next chunk as carry-in.
//   Sits between an operand producer and a result consumer, both with valid/ready handshakes.
//   Trades latency for area versus a fully parallel N-bit bypass adder.
// PARAMETERS
//   N   512  operand/result width in bits
//   W   64   chunk width processed per cycle; N % W == 0 required
//   M   4    bypass group size inside the chunk adder; W % M == 0 required
//   (derived) NCHUNK = N/W; chunk index counter width = clog2(NCHUNK), minimum 1
// PORTS
//   clk        in   1  single clock, rising edge
//   rst_n      in   1  asynchronous, active-low reset
//   in_valid   in   1  operands a, b, cin are valid
//   in_ready   out  1  controller can accept operands; equals (state==IDLE)
//   a          in   N  addend A
//   b          in   N  addend B
//   cin        in   1  carry-in of the full N-bit addition
//   out_valid  out  1  sum and cout are valid
//   out_ready  in   1  consumer accepts the result
//   sum        out  N  registered result (a+b+cin) mod 2^N
//   cout       out  1  registered carry-out of bit N-1
//   busy       out  1  high in RUN or DONE
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous):
//     state=IDLE, chunk index=0, carry reg=0, sum=0, cout=0, out_valid=0, busy=0.
//     in_ready=1 while in IDLE.
//     Reset asserted mid-operation discards all partial results; no output pulse is produced.
//   FSM states: IDLE -> RUN -> DONE -> IDLE.
//     IDLE: on in_valid & in_ready at a clock edge:
//       capture a, b, cin into internal operand registers; idx<=0; carry<=cin; go to RUN.
//     RUN: one chunk per cycle.
//       Combinational: {c, s} = bypass_add(A_reg[idx*W +: W], B_reg[idx*W +: W], carry).
//       Registered: sum[idx*W +: W]<=s; carry<=c; idx<=idx+1.
//       When idx==NCHUNK-1: cout<=c; out_valid<=1; go to DONE.
//     DONE: sum, cout and out_valid are held stable.
//       On out_ready: out_valid<=0; go to IDLE.
//   Chunk adder behaviour:
//     Per M-bit group, carry-out = (&(a^b)) ? group carry-in : ripple carry-out.
//     Result must be bit-exact to a+b+cin.
//   Latency: operands accepted at edge t; out_valid is high after edge t+NCHUNK.
//   Throughput: one operation per NCHUNK+2 cycles, assuming out_ready is high and in_valid is held.
//   in_ready=0 in RUN and DONE:
//     in_valid in those states is ignored; operands are not captured.
//     The producer must hold in_valid and its data until acceptance.
//   Operand inputs a, b, cin may change freely after acceptance; only the captured copies are used.
//   sum bits are updated chunk-by-chunk during RUN; they are defined only while out_valid=1.
//   Simultaneous out_ready and in_valid in DONE: the result handshake completes.
//     The new operands are accepted no earlier than the next cycle, in IDLE.
//   NCHUNK=1 (W==N): RUN lasts exactly one cycle.
//   Full-propagate case (a^b all ones): carry passes through every group and chunk unchanged; cout=cin.
//   No overflow flag is produced: cout is the only overflow indication.
// TESTING (N=16, W=4, M=4 unless stated)
//   1. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; out_valid asserted 4 cycles after accept.
//   2. a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0.
//      a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1 (full bypass path).
//   3. Backpressure: hold out_ready=0 for 10 cycles after out_valid, pulse in_valid with new data
//      -> sum, cout, out_valid stable; in_ready=0; new data not captured.
//      After out_ready=1, the next accept happens in IDLE.
//   4. Assert rst_n=0 during RUN at idx=2 -> immediately out_valid=0, sum=0, cout=0, busy=0, in_ready=1.
//      A following op a=0x00FF, b=0x0001 gives sum=0x0100, cout=0.
//   5. Change a and b on the cycle after acceptance -> result matches the captured operands only.
//   6. Defaults N=512, W=64, M=4: 2000 random ops with random in_valid/out_ready
//      -> each result equals a+b+cin (N+1 bits); in-order, none lost, none duplicated.

Source files
------------

// File: rtl/bpa_seq_add_ctrl.sv
// -----------------------------------------------------------------------------
// bpa_seq_add_ctrl
//
// Multi-cycle sequencer for wide (N-bit) additions. A single W-bit carry-bypass
// adder slice is reused across NCHUNK = N/W cycles, least significant chunk
// first. The carry out of each chunk is registered and becomes the carry in of
// the next chunk, so the full N-bit sum takes NCHUNK cycles instead of one very
// wide carry chain.
//
// The W-bit slice is built from M-bit bypass groups. Each group ripples its
// carry internally. When every bit of the group propagates (a^b all ones), the
// group carry-in is passed straight to the group carry-out and the ripple path
// is skipped. Both paths give the same value, so the slice is bit-exact to
// a+b+cin.
//
// Parameters
//   N  operand/result width in bits            (N % W == 0)
//   W  chunk width added per cycle             (W % M == 0)
//   M  bypass group size inside the chunk adder
//
// Ports
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  operands a, b, cin are valid
//   in_ready   out  1  operands can be accepted (high only in IDLE)
//   a          in   N  addend A
//   b          in   N  addend B
//   cin        in   1  carry-in of the full addition
//   out_valid  out  1  sum/cout are valid, held until out_ready
//   out_ready  in   1  consumer takes the result
//   sum        out  N  (a+b+cin) mod 2^N, registered
//   cout       out  1  carry-out of bit N-1, registered
//   busy       out  1  high in RUN or DONE
//
// Handshake
//   Operands are accepted on a clock edge where in_valid and in_ready are both
//   high. out_valid rises NCHUNK edges later. A result handshake and a new
//   operand acceptance never share an edge: the controller first returns to
//   IDLE and accepts new operands on the following edge at the earliest.
// -----------------------------------------------------------------------------
module bpa_seq_add_ctrl #(
  parameter int N = 512,
  parameter int W = 64,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         busy
);

  localparam int NCHUNK = N / W;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int NGRP   = W / M;

  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // ---------------------------------------------------------------------------
  // W-bit carry-bypass adder. Returns {carry_out, sum}.
  // Each M-bit group ripples its carry bit by bit. The group carry-out then
  // takes the bypass path (the group carry-in) when all M bits propagate, and
  // the ripple result otherwise.
  // ---------------------------------------------------------------------------
  function automatic logic [W:0] bypass_add(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         ci
  );
    logic [W-1:0] s;
    logic [M-1:0] grp_p;
    logic         grp_c;
    logic         rip_c;
    s     = {W{1'b0}};
    grp_c = ci;
    for (int g = 0; g < NGRP; g++) begin
      rip_c = grp_c;
      for (int k = 0; k < M; k++) begin
        s[g*M + k] = x[g*M + k] ^ y[g*M + k] ^ rip_c;
        rip_c      = (x[g*M + k] & y[g*M + k]) |
                     (rip_c & (x[g*M + k] ^ y[g*M + k]));
      end
      grp_p = x[g*M +: M] ^ y[g*M +: M];
      grp_c = (&grp_p) ? grp_c : rip_c;
    end
    return {grp_c, s};
  endfunction

  // State and datapath registers
  logic [1:0]    state_r;
  logic [IW-1:0] idx_r;
  logic          carry_r;
  logic [N-1:0]  a_r;        // captured A, shifted down one chunk per RUN cycle
  logic [N-1:0]  b_r;        // captured B, shifted down one chunk per RUN cycle
  logic [N-1:0]  sum_r;
  logic          cout_r;
  logic          out_valid_r;
  logic          in_ready_r;
  logic          busy_r;

  // Chunk adder signals
  logic [W:0]    add_res_s;
  logic [W-1:0]  chunk_sum_s;
  logic          chunk_cout_s;

  // Chunk adder: the current chunk always sits in the low W bits of a_r/b_r
  // because the operand registers shift right by W after every RUN cycle.
  always_comb begin
    add_res_s = bypass_add(a_r[W-1:0], b_r[W-1:0], carry_r);
  end

  assign chunk_sum_s  = add_res_s[W-1:0];
  assign chunk_cout_s = add_res_s[W];

  // Sequencer FSM and result registers.
  // in_ready and busy are registered copies of (state == IDLE) and
  // (state != IDLE). They are updated on the same edges as state_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      idx_r       <= {IW{1'b0}};
      carry_r     <= 1'b0;
      a_r         <= {N{1'b0}};
      b_r         <= {N{1'b0}};
      sum_r       <= {N{1'b0}};
      cout_r      <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            a_r        <= a;
            b_r        <= b;
            carry_r    <= cin;
            idx_r      <= {IW{1'b0}};
            state_r    <= S_RUN;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end

        S_RUN: begin
          // Drop the chunk just added so the next one lands in the low bits.
          a_r     <= a_r >> W;
          b_r     <= b_r >> W;
          carry_r <= chunk_cout_s;
          idx_r   <= idx_r + IDX_ONE;
          for (int i = 0; i < NCHUNK; i++) begin
            if (idx_r == IW'(i)) begin
              sum_r[i*W +: W] <= chunk_sum_s;
            end
          end
          if (idx_r == LAST_IDX) begin
            cout_r      <= chunk_cout_s;
            out_valid_r <= 1'b1;
            state_r     <= S_DONE;
          end
        end

        S_DONE: begin
          // Result is held until taken; in_valid is ignored here.
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= S_IDLE;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end
        end

        default: begin
          // Unreachable encoding: return to a clean idle state.
          state_r     <= S_IDLE;
          idx_r       <= {IW{1'b0}};
          carry_r     <= 1'b0;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign busy      = busy_r;

endmodule
